// File: rtl/nn_dense_layer_seq.sv
//-----------------------------------------------------------------------------
// nn_dense_layer_seq
//
// Time-multiplexed fully-connected layer. A feature vector of N_IN unsigned
// beats is buffered, then a single shared multiply-accumulate walks every
// output neuron, fetching its weights from an external synchronous ROM.
// Each neuron result is arithmetically shifted, saturated and offered on a
// valid/ready output port before the next neuron starts.
//
// Optional build macro:
//   NN_DENSE_RELU_EN  - negative results are clamped to 0 (ReLU), so
//                       out_data is always non-negative.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   feature beat handshake, in_data = feature i
//   w_rd, w_addr        weight ROM read strobe and address (j*N_IN + k)
//   w_data              weight returned one cycle after w_rd
//   out_valid/out_ready result handshake
//   out_data, out_idx   saturated result and its neuron index
//   busy                high while computing or emitting
//-----------------------------------------------------------------------------
// state   | meaning
// --------+-------------------------------------------------------------
// LOAD    | accepting feature beats into the feature buffer
// COMPUTE | N_IN+1 cycles: ROM reads on 0..N_IN-1, MACs on 1..N_IN
// EMIT    | result for neuron j held on the output until accepted
//-----------------------------------------------------------------------------
`timescale 1ns/1ps

module nn_dense_layer_seq #(
    parameter int N_IN  = 36,
    parameter int N_OUT = 10,
    parameter int IN_W  = 9,
    parameter int W_W   = 8,
    parameter int ACC_W = 24,
    parameter int OUT_W = 11,
    parameter int SHIFT = 0,
    parameter int WA_W  = 9
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [IN_W-1:0]          in_data,
    output logic [WA_W-1:0]          w_addr,
    output logic                     w_rd,
    input  logic [W_W-1:0]           w_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [OUT_W-1:0]         out_data,
    output logic [$clog2(N_OUT)-1:0] out_idx,
    output logic                     busy
);

    localparam int I_W = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam int K_W = $clog2(N_IN + 1);
    localparam int J_W = $clog2(N_OUT);
    localparam int P_W = IN_W + W_W + 1;

    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((2 ** (OUT_W - 1)) - 1);
    // Two's complement: ~MAX == -MAX-1 == -2^(OUT_W-1)
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [1:0] {
        ST_LOAD    = 2'd0,
        ST_COMPUTE = 2'd1,
        ST_EMIT    = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [I_W-1:0]          i_cnt;
    logic [K_W-1:0]          k_cnt;
    logic [J_W-1:0]          j_cnt;
    logic [WA_W-1:0]         w_base;
    logic signed [ACC_W-1:0] acc;
    logic [IN_W-1:0]         feat_mem [N_IN];

    logic                    in_fire;
    logic                    last_beat;
    logic                    last_k;
    logic                    last_j;
    logic [I_W-1:0]          k_idx;
    logic [IN_W-1:0]         feat_sel;
    logic signed [P_W-1:0]   prod;
    logic signed [ACC_W-1:0] prod_ext;
    logic signed [ACC_W-1:0] acc_sh;
    logic [OUT_W-1:0]        sat_val;

    assign in_fire   = in_valid && (state == ST_LOAD);
    assign last_beat = in_fire && (i_cnt == I_W'(N_IN - 1));
    assign last_k    = (k_cnt == K_W'(N_IN));
    assign last_j    = (j_cnt == J_W'(N_OUT - 1));

    //-------------------------------------------------------------------------
    // State register
    //-------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    //-------------------------------------------------------------------------
    // Next state and handshake outputs
    //-------------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        w_rd      = 1'b0;
        busy      = 1'b1;
        case (state)
            ST_LOAD: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (last_beat) begin
                    state_nxt = ST_COMPUTE;
                end
            end
            ST_COMPUTE: begin
                // Last cycle only consumes the final weight, no new read.
                w_rd = !last_k;
                if (last_k) begin
                    state_nxt = ST_EMIT;
                end
            end
            ST_EMIT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = last_j ? ST_LOAD : ST_COMPUTE;
                end
            end
            default: begin
                state_nxt = ST_LOAD;
            end
        endcase
    end

    // w_base tracks j*N_IN so no multiplier is needed for the address.
    assign w_addr  = w_rd ? (w_base + WA_W'(k_cnt)) : '0;
    assign out_idx = j_cnt;

    //-------------------------------------------------------------------------
    // MAC datapath: weight read on cycle k-1 pairs with feature k-1 on cycle k
    //-------------------------------------------------------------------------
    always_comb begin
        k_idx    = '0;
        if (k_cnt != '0) begin
            k_idx = I_W'(k_cnt - 1'b1);
        end
        feat_sel = feat_mem[k_idx];
        prod     = P_W'($signed({1'b0, feat_sel})) * P_W'($signed(w_data));
        prod_ext = {{(ACC_W - P_W){prod[P_W-1]}}, prod};
    end

    //-------------------------------------------------------------------------
    // Output shift and saturation
    //-------------------------------------------------------------------------
    always_comb begin
        acc_sh  = acc >>> SHIFT;
        sat_val = acc_sh[OUT_W-1:0];
`ifdef NN_DENSE_RELU_EN
        if (acc_sh[ACC_W-1]) begin
            sat_val = '0;
        end else if (acc_sh > SAT_MAX) begin
            sat_val = SAT_MAX[OUT_W-1:0];
        end
`else
        if (acc_sh > SAT_MAX) begin
            sat_val = SAT_MAX[OUT_W-1:0];
        end else if (acc_sh < SAT_MIN) begin
            sat_val = SAT_MIN[OUT_W-1:0];
        end
`endif
    end

    always_comb begin
        out_data = '0;
        if (state == ST_EMIT) begin
            out_data = sat_val;
        end
    end

    //-------------------------------------------------------------------------
    // Counters and accumulator
    //-------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_cnt  <= '0;
            k_cnt  <= '0;
            j_cnt  <= '0;
            w_base <= '0;
            acc    <= '0;
        end else begin
            case (state)
                ST_LOAD: begin
                    if (in_fire) begin
                        if (last_beat) begin
                            i_cnt  <= '0;
                            k_cnt  <= '0;
                            j_cnt  <= '0;
                            w_base <= '0;
                            acc    <= '0;
                        end else begin
                            i_cnt <= i_cnt + 1'b1;
                        end
                    end
                end
                ST_COMPUTE: begin
                    if (k_cnt != '0) begin
                        acc <= acc + prod_ext;
                    end
                    k_cnt <= last_k ? '0 : (k_cnt + 1'b1);
                end
                ST_EMIT: begin
                    // Backpressure: everything frozen until out_ready.
                    if (out_ready) begin
                        acc <= '0;
                        if (last_j) begin
                            j_cnt  <= '0;
                            w_base <= '0;
                        end else begin
                            j_cnt  <= j_cnt + 1'b1;
                            w_base <= w_base + WA_W'(N_IN);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    //-------------------------------------------------------------------------
    // Feature buffer, contents are don't-care after reset
    //-------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (in_fire) begin
            feat_mem[i_cnt] <= in_data;
        end
    end

endmodule

// File: tb/tb_nn_dense_layer_seq.sv
`timescale 1ns/1ps

module tb_nn_dense_layer_seq;

    localparam int N_IN  = 36;
    localparam int N_OUT = 10;
    localparam int IN_W  = 9;
    localparam int W_W   = 8;
    localparam int ACC_W = 24;
    localparam int OUT_W = 11;
    localparam int SHIFT = 0;
    localparam int WA_W  = 9;
    localparam longint MAXV = (64'sd1 <<< (OUT_W - 1)) - 1;
    localparam longint MINV = -(64'sd1 <<< (OUT_W - 1));

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b0;
    logic                     in_valid = 1'b0;
    logic                     in_ready;
    logic [IN_W-1:0]          in_data = '0;
    logic [WA_W-1:0]          w_addr;
    logic                     w_rd;
    logic [W_W-1:0]           w_data = '0;
    logic                     out_valid;
    logic                     out_ready = 1'b1;
    logic [OUT_W-1:0]         out_data;
    logic [$clog2(N_OUT)-1:0] out_idx;
    logic                     busy;

    int xv   [N_IN];
    int wmem [N_IN*N_OUT];
    int exp_d [$];
    int exp_i [$];
    int n_vec = 0;
    int n_err = 0;

    nn_dense_layer_seq #(
        .N_IN(N_IN), .N_OUT(N_OUT), .IN_W(IN_W), .W_W(W_W), .ACC_W(ACC_W),
        .OUT_W(OUT_W), .SHIFT(SHIFT), .WA_W(WA_W)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .w_addr(w_addr), .w_rd(w_rd), .w_data(w_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_idx(out_idx), .busy(busy)
    );

    always #5 clk = ~clk;

    // External synchronous weight ROM
    always @(posedge clk) begin
        if (w_rd) w_data <= W_W'(wmem[int'(w_addr)]);
    end

    // Reference: dot product, shift, clamp
    function automatic int model(input int j);
        longint s = 0;
        for (int i = 0; i < N_IN; i++) s += longint'(xv[i]) * longint'(wmem[j*N_IN + i]);
        s = s >>> SHIFT;
`ifdef NN_DENSE_RELU_EN
        if (s < 0) s = 0;
`endif
        if (s > MAXV) s = MAXV;
        if (s < MINV) s = MINV;
        return int'(s);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name,
                     $signed(act), act, $signed(expv), expv);
        end
    endtask

    // Output compare process: any cycle a result is presented it must equal
    // the head of the expected queue, and weight reads must be idle.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            n_vec++;
            if (exp_d.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_out: got idx %0d data %0d, expected no result",
                         out_idx, $signed(out_data));
            end else begin
                if (int'($signed(out_data)) != exp_d[0] || int'(out_idx) != exp_i[0]) begin
                    n_err++;
                    $display("FAIL out_result: got idx %0d data %0d expected idx %0d data %0d",
                             out_idx, $signed(out_data), exp_i[0], exp_d[0]);
                end
                if (!out_ready) begin
                    n_vec++;
                    if (w_rd !== 1'b0) begin
                        n_err++;
                        $display("FAIL stall_w_rd: got %b expected 0", w_rd);
                    end
                end else begin
                    void'(exp_d.pop_front());
                    void'(exp_i.pop_front());
                end
            end
        end
    end

    task automatic feed_beats(input bit rnd_in);
        int i = 0;
        int guard = 0;
        while (i < N_IN && guard < 2000) begin
            in_valid = rnd_in ? ($urandom_range(0, 3) != 0) : 1'b1;
            in_data  = in_valid ? IN_W'(xv[i]) : IN_W'($urandom);
            @(negedge clk);
            if (in_valid && in_ready) i++;
            @(posedge clk); #1;
            guard++;
        end
        in_valid = 1'b0;
        if (i != N_IN) check("load_timeout", i, N_IN);
    endtask

    task automatic run_vector(input bit rnd_in, input bit rnd_out, input bit lat_chk, input bit bp_test);
        int guard = 0;
        int lat = 0;
        bit bp_done = 0;
        for (int j = 0; j < N_OUT; j++) begin
            exp_d.push_back(model(j));
            exp_i.push_back(j);
        end
        out_ready = 1'b1;
        feed_beats(rnd_in);
        if (lat_chk) begin
            while (!out_valid && lat < 100) begin
                @(posedge clk); #1;
                lat++;
            end
            check("first_out_latency", lat, 37);
        end
        while (exp_d.size() > 0 && guard < 20000) begin
            if (bp_test && !bp_done && out_valid && out_idx == 3) begin
                out_ready = 1'b0;
                in_valid  = 1'b0;
                repeat (5) begin @(posedge clk); #1; end
                check("bp_hold_valid", out_valid, 1);
                out_ready = 1'b1;
                @(posedge clk); #1;
                check("bp_resume_w_rd", w_rd, 1);
                check("bp_resume_addr", w_addr, 4*N_IN);
                check("bp_resume_valid", out_valid, 0);
                bp_done = 1;
            end else begin
                out_ready = rnd_out ? ($urandom_range(0, 2) != 0) : 1'b1;
                in_valid  = (rnd_in && busy) ? 1'($urandom_range(0, 1)) : 1'b0;
                in_data   = IN_W'($urandom);
                @(posedge clk); #1;
                guard++;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        if (exp_d.size() != 0) begin
            check("results_timeout", exp_d.size(), 0);
            exp_d.delete();
            exp_i.delete();
        end
        check("back_to_load", {busy, in_ready}, 2'b01);
        if (bp_test) check("bp_exercised", bp_done, 1);
    endtask

    task automatic fill(input int x, input int w);
        for (int i = 0; i < N_IN; i++) xv[i] = x;
        for (int i = 0; i < N_IN*N_OUT; i++) wmem[i] = w;
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_w_rd", w_rd, 0);
        check("rst_w_addr", w_addr, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_idx", out_idx, 0);
        @(posedge clk); #1;

        // Pin the model with hand-computed values
        fill(1, 1);
        check("model_unity", model(0), 36);
        fill(511, 127);
        check("model_pos_sat", model(5), 1023);
        fill(511, -128);
`ifdef NN_DENSE_RELU_EN
        check("model_neg", model(9), 0);
`else
        check("model_neg", model(9), -1024);
`endif
        xv[0] = 3; xv[1] = 2;
        for (int i = 2; i < N_IN; i++) xv[i] = 0;
        wmem[N_IN] = -5; wmem[N_IN+1] = 4;
`ifdef NN_DENSE_RELU_EN
        check("model_small", model(1), 0);
`else
        check("model_small", model(1), -7);
`endif

        // Directed vectors
        fill(1, 1);
        run_vector(0, 0, 1, 0);
        fill(511, 127);
        run_vector(0, 0, 0, 0);
        fill(511, -128);
        run_vector(0, 0, 0, 0);

        // Backpressure during neuron 3
        for (int i = 0; i < N_IN; i++) xv[i] = $urandom_range(0, 511);
        for (int i = 0; i < N_IN*N_OUT; i++) wmem[i] = $urandom_range(0, 255) - 128;
        run_vector(0, 0, 0, 1);

        // Reset in the middle of COMPUTE
        feed_beats(0);
        repeat (10) @(posedge clk);
        #1;
        check("mid_busy", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_in_ready", in_ready, 1);
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_w_rd", w_rd, 0);
        check("mid_rst_w_addr", w_addr, 0);
        check("mid_rst_out_data", out_data, 0);
        check("mid_rst_out_idx", out_idx, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Random sparse vectors (every tenth one dense) with random handshakes
        for (int v = 0; v < 30; v++) begin
            for (int i = 0; i < N_IN; i++) begin
                if (v % 10 == 9) xv[i] = $urandom_range(0, 511);
                else xv[i] = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 511) : 0;
            end
            for (int i = 0; i < N_IN*N_OUT; i++) wmem[i] = $urandom_range(0, 255) - 128;
            run_vector(1, 1, 0, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/nn_dense_layer_seq.md
Name: nn_dense_layer_seq

Overview:
Time-multiplexed fully-connected neural layer. It is the sequential, parametrised successor to the combinational 36-in/10-out network top.
- Input feature vector arrives as a stream over a valid/ready handshake.
- One shared MAC computes each output neuron using weights read from an external synchronous ROM.
- Results are shifted, saturated and streamed out one neuron per handshake.
- Instances chain layer-to-layer inside the PLL neural network datapath.

Parameters:
N_IN, 36, number of input features per vector
N_OUT, 10, number of output neurons
IN_W, 9, input feature width, unsigned
W_W, 8, weight width, signed two's complement
ACC_W, 24, accumulator width, signed; must be >= IN_W+W_W+1+clog2(N_IN)
OUT_W, 11, output width, signed (unsigned when ReLU is compiled in)
SHIFT, 0, arithmetic right shift applied to accumulator before saturation
WA_W, 9, weight address width; must be >= clog2(N_IN*N_OUT)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  input feature beat valid
in_ready  output  1  block accepts a feature beat
in_data  input  IN_W  feature value, beat i = feature i
w_addr  output  WA_W  weight ROM address = j*N_IN + i
w_rd  output  1  weight ROM read enable
w_data  input  W_W  weight, valid one cycle after w_rd
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
out_data  output  OUT_W  saturated neuron result
out_idx  output  clog2(N_OUT)  neuron index j of out_data
busy  output  1  high in COMPUTE or EMIT

Behaviour:
- Reset (async, any state): state=LOAD; all counters 0; accumulator 0. Outputs: in_ready=1, out_valid=0, out_data=0, out_idx=0, w_rd=0, w_addr=0, busy=0. Feature buffer contents are don't-care.
- LOAD: in_ready=1. Each in_valid&in_ready cycle writes in_data to buf[i] and increments i. On acceptance of beat N_IN-1: in_ready drops the next cycle, i=0, j=0, acc=0, state goes to COMPUTE.
- COMPUTE: runs N_IN+1 cycles per neuron.
  - Cycles 0..N_IN-1: w_rd=1 and w_addr=j*N_IN+k.
  - Cycles 1..N_IN: acc += $signed({1'b0,buf[k-1]}) * $signed(w_data), sign-extended to ACC_W.
  - After the final accumulate, state goes to EMIT.
- EMIT:
  - r = acc >>> SHIFT, then saturate to OUT_W signed range: max 2^(OUT_W-1)-1, min -2^(OUT_W-1). Defaults give 1023 / -1024.
  - out_valid=1, out_data=r, out_idx=j. Both are held stable until out_ready.
  - On out_valid&out_ready: out_valid=0 the next cycle. If j<N_OUT-1: j++, acc=0, back to COMPUTE. Else: state goes to LOAD and in_ready=1 the next cycle.
- Backpressure: while out_ready=0 in EMIT, w_rd=0 and no counter or accumulator changes.
- Throughput: one vector per N_IN + N_OUT*(N_IN+2) cycles minimum. Defaults give 416.
- in_valid outside LOAD is ignored; no beat is lost because in_ready=0.
- Accumulator does not wrap under the ACC_W rule. Saturation is applied only at EMIT.
- busy = (state != LOAD).

Optional Feature:
NN_DENSE_RELU_EN
- Defined: r<0 outputs 0. Positive r saturates to 2^(OUT_W-1)-1. out_data is non-negative and ready for the next layer's unsigned input.
- Undefined: plain signed saturation as above.

Test Plan:
- Reset/idle: rst_n low for 3 cycles, then high -> in_ready=1, out_valid=0, busy=0. Assert rst_n low mid-COMPUTE -> all outputs return to reset values immediately.
- Unity: all x=1, all w=1, SHIFT=0 -> ten results out_data=36 with out_idx 0..9. First out_valid 37 cycles after the last input beat.
- Positive saturation: all x=0x1FF, all w=127 -> out_data=1023 for every neuron.
- Negative / ReLU: all x=0x1FF, all w=-128 -> out_data=-1024 (0x400) without macro; 0 with NN_DENSE_RELU_EN.
- Backpressure: out_ready=0 for 5 cycles during neuron 3 -> out_valid held, out_data/out_idx stable, w_rd=0. On release, neuron 4 starts the next cycle.
- Random: 30 vectors of sparse 9-bit features (e.g. x13=0x1C, x15=0xD, x33=0x39, rest 0) with random weights -> results match a bit-accurate reference model. in_valid toggled randomly throughout.
